// File: rtl/axi_m0_port_slice.sv
// Full-throughput AXI register slice for NoC master port M0: every channel is a 2-entry skid buffer
// with an input-side handshake-stability checker. Define AXI_USER_EN to append a 1-bit USER LSB.
module axi_m0_port_slice #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
`ifdef AXI_USER_EN
    localparam int USER_W = 1,
`else
    localparam int USER_W = 0,
`endif
    localparam int AW_W = ID_W + ADDR_W + LEN_W + 21 + USER_W,
    localparam int W_W  = DATA_W + DATA_W / 8 + 1 + USER_W,
    localparam int B_W  = ID_W + 2 + USER_W,
    localparam int R_W  = ID_W + DATA_W + 3 + USER_W
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic            s_aw_valid,
    output logic            s_aw_ready,
    input  logic [AW_W-1:0] s_aw_pld,
    output logic            m_aw_valid,
    input  logic            m_aw_ready,
    output logic [AW_W-1:0] m_aw_pld,
    input  logic            s_w_valid,
    output logic            s_w_ready,
    input  logic [W_W-1:0]  s_w_pld,
    output logic            m_w_valid,
    input  logic            m_w_ready,
    output logic [W_W-1:0]  m_w_pld,
    input  logic            s_ar_valid,
    output logic            s_ar_ready,
    input  logic [AW_W-1:0] s_ar_pld,
    output logic            m_ar_valid,
    input  logic            m_ar_ready,
    output logic [AW_W-1:0] m_ar_pld,
    input  logic            m_b_valid,
    output logic            m_b_ready,
    input  logic [B_W-1:0]  m_b_pld,
    output logic            s_b_valid,
    input  logic            s_b_ready,
    output logic [B_W-1:0]  s_b_pld,
    input  logic            m_r_valid,
    output logic            m_r_ready,
    input  logic [R_W-1:0]  m_r_pld,
    output logic            s_r_valid,
    input  logic            s_r_ready,
    output logic [R_W-1:0]  s_r_pld,
    output logic [4:0]      proto_err
);

    // Channel index doubles as the proto_err bit: {R,B,AR,W,AW}.
    for (genvar g = 0; g < 5; g++) begin : g_ch
        localparam int PLD_W = (g == 0 || g == 2) ? AW_W : (g == 1) ? W_W : (g == 3) ? B_W : R_W;

        logic             w_in_valid;
        logic             w_out_ready;
        logic [PLD_W-1:0] w_in_pld;
        logic             w_in_hs;
        logic             w_main_free;
        logic             r_main_valid;
        logic             r_skid_valid;
        logic             r_in_ready;
        logic             r_stall;
        logic             r_err;
        logic [PLD_W-1:0] r_main_pld;
        logic [PLD_W-1:0] r_skid_pld;
        logic [PLD_W-1:0] r_stall_pld;

        assign w_in_hs     = w_in_valid && r_in_ready;
        assign w_main_free = !r_main_valid || w_out_ready;

        // NOTE: payload registers are reset too, so nothing stale is ever visible on an output.
        always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b0;
                r_stall      <= 1'b0;
                r_err        <= 1'b0;
                r_main_pld   <= '0;
                r_skid_pld   <= '0;
                r_stall_pld  <= '0;
            end else begin
                if (w_main_free) begin
                    if (r_skid_valid) begin
                        r_main_valid <= 1'b1;
                        r_main_pld   <= r_skid_pld;
                        r_skid_valid <= 1'b0;
                    end else begin
                        r_main_valid <= w_in_hs;
                        if (w_in_hs) r_main_pld <= w_in_pld;
                    end
                end else if (w_in_hs) begin
                    r_skid_valid <= 1'b1;
                    r_skid_pld   <= w_in_pld;
                end
                // Ready is registered: high exactly when the skid slot will be empty.
                r_in_ready <= w_main_free || !(r_skid_valid || w_in_hs);

                r_stall     <= w_in_valid && !r_in_ready;
                r_stall_pld <= w_in_pld;
                if (r_stall && (!w_in_valid || w_in_pld != r_stall_pld)) r_err <= 1'b1;
            end
        end

        assign proto_err[g] = r_err;

        if (g == 0) begin : g_aw
            assign w_in_valid  = s_aw_valid;
            assign w_in_pld    = s_aw_pld;
            assign w_out_ready = m_aw_ready;
            assign s_aw_ready  = r_in_ready;
            assign m_aw_valid  = r_main_valid;
            assign m_aw_pld    = r_main_pld;
        end else if (g == 1) begin : g_w
            assign w_in_valid  = s_w_valid;
            assign w_in_pld    = s_w_pld;
            assign w_out_ready = m_w_ready;
            assign s_w_ready   = r_in_ready;
            assign m_w_valid   = r_main_valid;
            assign m_w_pld     = r_main_pld;
        end else if (g == 2) begin : g_ar
            assign w_in_valid  = s_ar_valid;
            assign w_in_pld    = s_ar_pld;
            assign w_out_ready = m_ar_ready;
            assign s_ar_ready  = r_in_ready;
            assign m_ar_valid  = r_main_valid;
            assign m_ar_pld    = r_main_pld;
        end else if (g == 3) begin : g_b
            assign w_in_valid  = m_b_valid;
            assign w_in_pld    = m_b_pld;
            assign w_out_ready = s_b_ready;
            assign m_b_ready   = r_in_ready;
            assign s_b_valid   = r_main_valid;
            assign s_b_pld     = r_main_pld;
        end else begin : g_r
            assign w_in_valid  = m_r_valid;
            assign w_in_pld    = m_r_pld;
            assign w_out_ready = s_r_ready;
            assign m_r_ready   = r_in_ready;
            assign s_r_valid   = r_main_valid;
            assign s_r_pld     = r_main_pld;
        end
    end

endmodule

// File: tb/tb_axi_m0_port_slice.sv
// Self-checking bench for axi_m0_port_slice: directed scenarios plus a randomized run scored against
// a per-channel 2-deep FIFO model (ready = fewer than 2 held beats, valid = at least 1 held beat).
module tb_axi_m0_port_slice;
    localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, LEN_W = 4;
`ifdef AXI_USER_EN
    localparam int USER_W = 1;
`else
    localparam int USER_W = 0;
`endif
    localparam int AW_W = ID_W + ADDR_W + LEN_W + 21 + USER_W;
    localparam int W_W  = DATA_W + DATA_W / 8 + 1 + USER_W;
    localparam int B_W  = ID_W + 2 + USER_W;
    localparam int R_W  = ID_W + DATA_W + 3 + USER_W;
    localparam int CH_AW = 0, CH_W = 1, CH_AR = 2, CH_B = 3, CH_R = 4;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [4:0]  iv;
    logic [4:0]  ordy;
    logic [63:0] ip [5];
    wire  [4:0]  ir;
    wire  [4:0]  ov;
    wire  [63:0] op [5];
    wire  [4:0]  proto_err;
    wire  [AW_W-1:0] w_aw_o, w_ar_o;
    wire  [W_W-1:0]  w_w_o;
    wire  [B_W-1:0]  w_b_o;
    wire  [R_W-1:0]  w_r_o;
    int n_total = 0;
    int n_pass  = 0;

    always #5 ACLK = ~ACLK;

    axi_m0_port_slice dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_aw_valid(iv[CH_AW]), .s_aw_ready(ir[CH_AW]), .s_aw_pld(ip[CH_AW][AW_W-1:0]),
        .m_aw_valid(ov[CH_AW]), .m_aw_ready(ordy[CH_AW]), .m_aw_pld(w_aw_o),
        .s_w_valid(iv[CH_W]), .s_w_ready(ir[CH_W]), .s_w_pld(ip[CH_W][W_W-1:0]),
        .m_w_valid(ov[CH_W]), .m_w_ready(ordy[CH_W]), .m_w_pld(w_w_o),
        .s_ar_valid(iv[CH_AR]), .s_ar_ready(ir[CH_AR]), .s_ar_pld(ip[CH_AR][AW_W-1:0]),
        .m_ar_valid(ov[CH_AR]), .m_ar_ready(ordy[CH_AR]), .m_ar_pld(w_ar_o),
        .m_b_valid(iv[CH_B]), .m_b_ready(ir[CH_B]), .m_b_pld(ip[CH_B][B_W-1:0]),
        .s_b_valid(ov[CH_B]), .s_b_ready(ordy[CH_B]), .s_b_pld(w_b_o),
        .m_r_valid(iv[CH_R]), .m_r_ready(ir[CH_R]), .m_r_pld(ip[CH_R][R_W-1:0]),
        .s_r_valid(ov[CH_R]), .s_r_ready(ordy[CH_R]), .s_r_pld(w_r_o),
        .proto_err(proto_err)
    );

    assign op[CH_AW] = 64'(w_aw_o);
    assign op[CH_W]  = 64'(w_w_o);
    assign op[CH_AR] = 64'(w_ar_o);
    assign op[CH_B]  = 64'(w_b_o);
    assign op[CH_R]  = 64'(w_r_o);

    function automatic int chw(int ch);
        return (ch == CH_AW || ch == CH_AR) ? AW_W : (ch == CH_W) ? W_W : (ch == CH_B) ? B_W : R_W;
    endfunction

    function automatic logic [63:0] rnd_pld(int ch);
        logic [63:0] m;
        m = (64'd1 << chw(ch)) - 64'd1;
        return {$urandom, $urandom} & m;
    endfunction

    function automatic logic [63:0] w_beat(int i);
        logic [36:0] b;
        b = {i[31:0], 4'hF, (i == 15)};
        return 64'(b) << USER_W;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ordy = '0;
        for (int ch = 0; ch < 5; ch++) begin
            iv[ch] = 1'b1;
            ip[ch] = rnd_pld(ch);
        end
        repeat (3) tick();
        #2 ARESET = 1'b1;
        #1;
        n_total++;
        if (ov !== 5'b0) $display("FAIL reset_valids: got %b want 00000", ov); else n_pass++;
        n_total++;
        if (ir !== 5'b0) $display("FAIL reset_readies: got %b want 00000", ir); else n_pass++;
        n_total++;
        if (proto_err !== 5'b0) $display("FAIL reset_proto_err: got %b want 00000", proto_err); else n_pass++;
        iv   = '0;
        ordy = '1;
        repeat (2) tick();
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        n_total++;
        if (ir !== 5'b0) $display("FAIL release_ready_early: got %b want 00000", ir); else n_pass++;
        tick();
        n_total++;
        if (ir !== 5'b11111) $display("FAIL release_ready: got %b want 11111", ir); else n_pass++;
        n_total++;
        if (ov !== 5'b0) $display("FAIL release_valids: got %b want 00000", ov); else n_pass++;
    endtask

    task automatic test_pass_through();
        logic [63:0] exp;
        exp = 64'({4'd2, 32'h0000_1000, 4'd3, 1'b0, 3'd2, 2'd1, 4'd3, 3'd0, 4'd0, 4'd0}) << USER_W;
        ip[CH_AW] = exp;
        iv[CH_AW] = 1'b1;
        @(negedge ACLK);
        n_total++;
        if ({ov[CH_AW], ir[CH_AW]} !== 2'b01) $display("FAIL aw_before_edge: got v/r %b want 01", {ov[CH_AW], ir[CH_AW]}); else n_pass++;
        tick();
        n_total++;
        if ({ov[CH_AW], op[CH_AW]} !== {1'b1, exp}) $display("FAIL aw_pass: got v=%b %h want v=1 %h", ov[CH_AW], op[CH_AW], exp); else n_pass++;
        iv[CH_AW] = 1'b0;
        tick();
        n_total++;
        if (ov[CH_AW] !== 1'b0) $display("FAIL aw_drain: got valid %b want 0", ov[CH_AW]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 16; i++) begin
            iv[CH_W] = (i < 16);
            if (i < 16) ip[CH_W] = w_beat(i);
            if (i > 0) begin
                n_total++;
                if ({ov[CH_W], op[CH_W]} !== {1'b1, w_beat(i - 1)})
                    $display("FAIL w_b2b_beat%0d: got v=%b %h want v=1 %h", i - 1, ov[CH_W], op[CH_W], w_beat(i - 1));
                else n_pass++;
            end
            if (i < 16) begin
                n_total++;
                if (ir[CH_W] !== 1'b1) $display("FAIL w_b2b_ready%0d: got %b want 1", i, ir[CH_W]); else n_pass++;
            end
            tick();
        end
        n_total++;
        if (ov[CH_W] !== 1'b0) $display("FAIL w_b2b_end: got valid %b want 0", ov[CH_W]); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [63:0] r [3];
        int n_in, n_out;
        logic acc;
        for (int k = 0; k < 3; k++) r[k] = rnd_pld(CH_R);
        ordy[CH_R] = 1'b0;
        n_in = 0;
        for (int c = 0; c < 5; c++) begin
            iv[CH_R] = 1'b1;
            ip[CH_R] = r[n_in];
            @(negedge ACLK);
            acc = ir[CH_R];
            tick();
            if (acc) n_in++;
        end
        n_total++;
        if (n_in !== 2) $display("FAIL r_bp_accepted: got %0d want 2", n_in); else n_pass++;
        n_total++;
        if ({ir[CH_R], ov[CH_R]} !== 2'b01) $display("FAIL r_bp_stall: got ready/valid %b want 01", {ir[CH_R], ov[CH_R]}); else n_pass++;
        ordy[CH_R] = 1'b1;
        n_out = 0;
        for (int c = 0; c < 12 && n_out < 3; c++) begin
            iv[CH_R] = (n_in < 3);
            if (n_in < 3) ip[CH_R] = r[n_in];
            @(negedge ACLK);
            acc = iv[CH_R] && ir[CH_R];
            if (ov[CH_R]) begin
                n_total++;
                if (op[CH_R] !== r[n_out]) $display("FAIL r_bp_beat%0d: got %h want %h", n_out, op[CH_R], r[n_out]); else n_pass++;
                n_out++;
            end
            tick();
            if (acc) n_in++;
        end
        iv[CH_R] = 1'b0;
        n_total++;
        if (n_out !== 3) $display("FAIL r_bp_drain: got %0d beats want 3", n_out); else n_pass++;
        n_total++;
        if (ov[CH_R] !== 1'b0) $display("FAIL r_bp_dup: got valid %b want 0", ov[CH_R]); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [63:0] b [3];
        int n_in;
        logic acc;
        for (int k = 0; k < 3; k++) b[k] = rnd_pld(CH_B);
        ordy[CH_B] = 1'b0;
        n_in = 0;
        for (int c = 0; c < 3; c++) begin
            iv[CH_B] = 1'b1;
            ip[CH_B] = b[n_in];
            @(negedge ACLK);
            acc = ir[CH_B];
            tick();
            if (acc) n_in++;
        end
        n_total++;
        if ({n_in == 2, ir[CH_B]} !== 2'b10) $display("FAIL b_fill: got n_in=%0d ready=%b want 2/0", n_in, ir[CH_B]); else n_pass++;
        ordy[CH_B] = 1'b1;
        ip[CH_B] = b[2];
        @(negedge ACLK);
        n_total++;
        if ({ov[CH_B], op[CH_B]} !== {1'b1, b[0]}) $display("FAIL b_out0: got v=%b %h want v=1 %h", ov[CH_B], op[CH_B], b[0]); else n_pass++;
        tick();
        n_total++;
        if (ir[CH_B] !== 1'b1) $display("FAIL b_ready_rise: got %b want 1", ir[CH_B]); else n_pass++;
        n_total++;
        if ({ov[CH_B], op[CH_B]} !== {1'b1, b[1]}) $display("FAIL b_out1: got v=%b %h want v=1 %h", ov[CH_B], op[CH_B], b[1]); else n_pass++;
        tick();
        iv[CH_B] = 1'b0;
        n_total++;
        if ({ov[CH_B], op[CH_B]} !== {1'b1, b[2]}) $display("FAIL b_no_bubble: got v=%b %h want v=1 %h", ov[CH_B], op[CH_B], b[2]); else n_pass++;
        tick();
        n_total++;
        if (ov[CH_B] !== 1'b0) $display("FAIL b_drain: got valid %b want 0", ov[CH_B]); else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] mq [5][8];
        int wp [5];
        int rp [5];
        logic pend [5];
        logic gen, idle;
        int cnt;
        for (int ch = 0; ch < 5; ch++) begin
            wp[ch] = 0;
            rp[ch] = 0;
            pend[ch] = 1'b0;
        end
        idle = 1'b0;
        for (int c = 0; c < 460 && !idle; c++) begin
            gen = (c < 400);
            for (int ch = 0; ch < 5; ch++) begin
                if (!pend[ch]) begin
                    iv[ch] = gen && ($urandom_range(9) < 7);
                    ip[ch] = rnd_pld(ch);
                end
                ordy[ch] = !gen || ($urandom_range(9) < 6);
            end
            @(negedge ACLK);
            idle = !gen;
            for (int ch = 0; ch < 5; ch++) begin
                cnt = wp[ch] - rp[ch];
                n_total++;
                if (ov[ch] !== (cnt > 0)) $display("FAIL rnd_valid ch%0d cyc%0d: got %b want %b", ch, c, ov[ch], cnt > 0); else n_pass++;
                n_total++;
                if (ir[ch] !== (cnt < 2)) $display("FAIL rnd_ready ch%0d cyc%0d: got %b want %b", ch, c, ir[ch], cnt < 2); else n_pass++;
                if (ov[ch] && ordy[ch]) begin
                    n_total++;
                    if (op[ch] !== mq[ch][rp[ch] % 8])
                        $display("FAIL rnd_data ch%0d cyc%0d: got %h want %h", ch, c, op[ch], mq[ch][rp[ch] % 8]);
                    else n_pass++;
                    rp[ch]++;
                end
                if (iv[ch] && ir[ch]) begin
                    mq[ch][wp[ch] % 8] = ip[ch];
                    wp[ch]++;
                    pend[ch] = 1'b0;
                end else begin
                    pend[ch] = iv[ch];
                end
                if (pend[ch] || wp[ch] != rp[ch]) idle = 1'b0;
            end
            tick();
        end
        iv = '0;
        ordy = '1;
        n_total++;
        if (!idle) $display("FAIL rnd_drain: got busy want idle within budget"); else n_pass++;
        n_total++;
        if (proto_err !== 5'b0) $display("FAIL rnd_proto_err: got %b want 00000", proto_err); else n_pass++;
    endtask

    task automatic test_violation();
        ordy[CH_AR] = 1'b0;
        iv[CH_AR] = 1'b1;
        ip[CH_AR] = rnd_pld(CH_AR);
        tick();
        ip[CH_AR] = rnd_pld(CH_AR);
        tick();
        ip[CH_AR] = rnd_pld(CH_AR);
        n_total++;
        if (ir[CH_AR] !== 1'b0) $display("FAIL ar_full: got ready %b want 0", ir[CH_AR]); else n_pass++;
        tick();
        n_total++;
        if (proto_err !== 5'b0) $display("FAIL ar_no_err_yet: got %b want 00000", proto_err); else n_pass++;
        ip[CH_AR] = ip[CH_AR] ^ (64'd1 << (USER_W + 21 + LEN_W));
        tick();
        n_total++;
        if (proto_err !== 5'b00100) $display("FAIL ar_violation: got %b want 00100", proto_err); else n_pass++;
        iv[CH_AR] = 1'b0;
        ordy[CH_AR] = 1'b1;
        repeat (4) tick();
        n_total++;
        if ({proto_err, ov[CH_AR]} !== {5'b00100, 1'b0}) $display("FAIL ar_sticky: got err=%b valid=%b want 00100/0", proto_err, ov[CH_AR]); else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iv = '0;
        ordy = '1;
        for (int ch = 0; ch < 5; ch++) ip[ch] = '0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        tick();
        tick();
        test_reset();
        test_pass_through();
        test_back_to_back();
        test_backpressure();
        test_simultaneous();
        test_random();
        test_violation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
